// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative M-extension multiply/divide execution unit.
// Accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU micro-op at a time over
// a valid/ready request channel and returns a tagged 32-bit result over a
// valid/ready writeback channel. Multiplies take one datapath cycle, divides
// run a 32-step restoring algorithm on magnitudes followed by a sign fix-up.
// Divide-by-zero and signed overflow are resolved at accept time.
module muldiv_unit #(
  parameter int TAG_W = 6
) (
  input  logic             cpu_clock_i,
  input  logic             cpu_reset_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_uop_i,
  input  logic [31:0]      req_rs1_i,
  input  logic [31:0]      req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_data_o,
  output logic [TAG_W-1:0] res_tag_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Low two uop bits: select high/low product, signedness, quotient/remainder.
  logic [1:0]       op_q,   op_d;
  logic [TAG_W-1:0] tag_q,  tag_d;
  // Multiplicand, or dividend magnitude that shifts into the quotient.
  logic [31:0]      opa_q,  opa_d;
  // Multiplier, or divisor magnitude.
  logic [31:0]      opb_q,  opb_d;
  logic [31:0]      rem_q,  rem_d;
  logic [4:0]       cnt_q,  cnt_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [31:0]      res_q,  res_d;

  logic accept;

  // ---------------------------------------------------------------------------
  // Request decode (evaluated on the incoming operands)
  // ---------------------------------------------------------------------------
  logic        req_signed_div;
  logic        req_div_zero;
  logic        req_ovf;
  logic        req_special;
  logic [31:0] req_special_val;
  logic [31:0] rs1_mag;
  logic [31:0] rs2_mag;

  assign accept         = req_valid_i & req_ready_o;
  assign req_signed_div = req_uop_i[2] & ~req_uop_i[0];
  assign req_div_zero   = (req_rs2_i == 32'd0);
  assign req_ovf        = req_signed_div & (req_rs1_i == 32'h8000_0000) &
                          (req_rs2_i == 32'hFFFF_FFFF);
  assign req_special    = req_uop_i[2] & (req_div_zero | req_ovf);

  // Divide-by-zero wins over overflow (they are mutually exclusive anyway).
  assign req_special_val = req_div_zero ? (req_uop_i[1] ? req_rs1_i : 32'hFFFF_FFFF)
                                        : (req_uop_i[1] ? 32'd0     : 32'h8000_0000);

  // Magnitudes for signed division; raw values for everything else.
  assign rs1_mag = (req_signed_div & req_rs1_i[31]) ? (32'd0 - req_rs1_i) : req_rs1_i;
  assign rs2_mag = (req_signed_div & req_rs2_i[31]) ? (32'd0 - req_rs2_i) : req_rs2_i;

  // ---------------------------------------------------------------------------
  // Multiplier: operands sign/zero-extended to 64 bits; the low 64 bits of the
  // product equal those of the 33x33 signed product.
  // ---------------------------------------------------------------------------
  logic        mul_a_signed;
  logic        mul_b_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] mul_prod;

  assign mul_a_signed = ((op_q == 2'b01) | (op_q == 2'b10)) & opa_q[31];
  assign mul_b_signed = (op_q == 2'b01) & opb_q[31];
  assign mul_a        = {{32{mul_a_signed}}, opa_q};
  assign mul_b        = {{32{mul_b_signed}}, opb_q};
  assign mul_prod     = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Restoring divider step: shift remainder:quotient left, trial-subtract.
  // ---------------------------------------------------------------------------
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic        unused_diff_msb;

  assign div_shift       = {rem_q, opa_q[31]};
  assign div_diff        = div_shift - {1'b0, opb_q};
  assign div_ge          = (div_shift >= {1'b0, opb_q});
  // When the subtraction is kept the difference is below the divisor, so its
  // MSB is always zero.
  assign unused_diff_msb = div_diff[32];

  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign quo_fix = negq_q ? (32'd0 - opa_q) : opa_q;
  assign rem_fix = negr_q ? (32'd0 - rem_q) : rem_q;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register
  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    // NOTE: state is updated with <= so every flop samples pre-edge values;
    // blocking assignments here would create order-dependent simulation.
    if (cpu_reset_i) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (!req_uop_i[2])    state_d = S_MUL;
            else if (req_special) state_d = S_DONE;
            else                  state_d = S_DIV;
          end
        end
        S_MUL:   state_d = S_DONE;
        S_DIV:   if (cnt_q == 5'd31) state_d = S_FIX;
        S_FIX:   state_d = S_DONE;
        S_DONE:  if (res_ready_i) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake outputs derived from the current state
  always_comb begin
    req_ready_o = (state_q == S_IDLE) && !flush_i;
    res_valid_o = (state_q == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------

  // Datapath next-state: operand capture, multiply, divide step, sign fix-up
  always_comb begin
    // NOTE: each _d defaults to its _q so no branch leaves a variable
    // unassigned, which would otherwise infer a latch.
    op_d   = op_q;
    tag_d  = tag_q;
    opa_d  = opa_q;
    opb_d  = opb_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    negq_d = negq_q;
    negr_d = negr_q;
    res_d  = res_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = req_uop_i[1:0];
          tag_d  = req_tag_i;
          opa_d  = rs1_mag;
          opb_d  = rs2_mag;
          rem_d  = 32'd0;
          cnt_d  = 5'd0;
          negq_d = req_signed_div & (req_rs1_i[31] ^ req_rs2_i[31]);
          negr_d = req_signed_div & req_rs1_i[31];
          if (req_special) res_d = req_special_val;
        end
      end
      S_MUL: begin
        res_d = (op_q == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];
      end
      S_DIV: begin
        rem_d = div_ge ? div_diff[31:0] : div_shift[31:0];
        opa_d = {opa_q[30:0], div_ge};
        cnt_d = cnt_q + 5'd1;
      end
      S_FIX: begin
        res_d = op_q[1] ? rem_fix : quo_fix;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      op_q   <= 2'b00;
      tag_q  <= '0;
      opa_q  <= 32'd0;
      opb_q  <= 32'd0;
      rem_q  <= 32'd0;
      cnt_q  <= 5'd0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      res_q  <= 32'd0;
    end else begin
      op_q   <= op_d;
      tag_q  <= tag_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      rem_q  <= rem_d;
      cnt_q  <= cnt_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      res_q  <= res_d;
    end
  end

  assign res_data_o = res_q;
  assign res_tag_o  = tag_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: scoreboard of expected results filled
// at request accept and drained when the unit presents a result.
module tb_muldiv_unit;

  localparam int TAG_W = 6;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_uop;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t sb_q[$];

  muldiv_unit #(.TAG_W(TAG_W)) dut (
    .cpu_clock_i (clk),
    .cpu_reset_i (rst),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_uop_i   (req_uop),
    .req_rs1_i   (req_rs1),
    .req_rs2_i   (req_rs2),
    .req_tag_i   (req_tag),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_tag_o   (res_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: architectural result and latency of one operation.
  function automatic exp_t model(input logic [2:0] uop, input logic [31:0] a,
                                 input logic [31:0] b, input logic [TAG_W-1:0] tag);
    exp_t        e;
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    int          sa32, sb32;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = longint'({32'd0, a});
    ub   = longint'({32'd0, b});
    sa32 = $signed(a);
    sb32 = $signed(b);
    e.tag = tag;
    e.lat = 2;
    e.data = 32'd0;
    case (uop)
      OP_MUL:    begin p = sa * sb; e.data = p[31:0];  end
      OP_MULH:   begin p = sa * sb; e.data = p[63:32]; end
      OP_MULHSU: begin p = sa * ub; e.data = p[63:32]; end
      OP_MULHU:  begin p = ua * ub; e.data = p[63:32]; end
      default: begin
        e.lat = 34;
        if (b == 32'd0) begin
          e.lat  = 1;
          e.data = uop[1] ? a : 32'hFFFF_FFFF;
        end else if (!uop[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lat  = 1;
          e.data = uop[1] ? 32'd0 : 32'h8000_0000;
        end else if (!uop[0]) begin
          e.data = uop[1] ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
        end else begin
          e.data = uop[1] ? (a % b) : (a / b);
        end
      end
    endcase
    return e;
  endfunction

  // Present a request (called at a negedge), wait for acceptance, push the
  // expected result. Returns at the negedge following the accept edge.
  task automatic issue_req(input logic [2:0] uop, input logic [31:0] a,
                           input logic [31:0] b, input logic [TAG_W-1:0] tag,
                           output int acc_cyc);
    int n;
    req_uop   = uop;
    req_rs1   = a;
    req_rs2   = b;
    req_tag   = tag;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    acc_cyc = cyc;
    if (!req_ready) begin
      errors++;
      $display("FAIL accept_timeout: req_ready_o=%0b after %0d cycles, required 1", req_ready, n);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back(model(uop, a, b, tag));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for res_valid_o (bounded), pop the scoreboard and compare latency,
  // data and tag. Returns at the negedge where the result is visible.
  task automatic collect_result(input string name, output exp_t e);
    int k;
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty when collecting", name);
      e = '{data: 32'd0, tag: '0, lat: 0};
      return;
    end
    e = sb_q.pop_front();
    if (!res_valid) begin
      errors++;
      $display("FAIL %s_timeout: res_valid_o=0 after 100 cycles, required 1", name);
      return;
    end
    checks++;
    if (k + 1 != e.lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d, expected %0d", name, k + 1, e.lat);
    end
    checks++;
    if (res_data !== e.data) begin
      errors++;
      $display("FAIL %s_data: got 0x%08h, expected 0x%08h", name, res_data, e.data);
    end
    checks++;
    if (res_tag !== e.tag) begin
      errors++;
      $display("FAIL %s_tag: got %0d, expected %0d", name, res_tag, e.tag);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] uop, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag);
    int   t;
    exp_t e;
    issue_req(uop, a, b, tag, t);
    collect_result(name, e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_uop   = 3'd0;
    req_rs1   = 32'd0;
    req_rs2   = 32'd0;
    req_tag   = '0;
    res_ready = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_data !== 32'd0 || res_tag !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b data=0x%08h tag=%0d, expected 0/0/0",
               res_valid, res_data, res_tag);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: req_ready_o=%0b, expected 1", req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op("mul_neg",     OP_MUL,    32'd7,         32'hFFFF_FFFD, 6'd5);
    run_op("mulh_min",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 6'd12);
    run_op("mulhu_max",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd13);
    run_op("mulhsu_neg1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd14);
  endtask

  task automatic test_div();
    run_op("div_neg7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 6'd20);
    run_op("rem_neg7_2",  OP_REM,  32'hFFFF_FFF9, 32'd2, 6'd21);
    run_op("divu_100_7",  OP_DIVU, 32'd100,       32'd7, 6'd22);
    run_op("remu_100_7",  OP_REMU, 32'd100,       32'd7, 6'd23);
  endtask

  task automatic test_div_special();
    run_op("div_by0",   OP_DIV,  32'd5,         32'd0,         6'd30);
    run_op("remu_by0",  OP_REMU, 32'd5,         32'd0,         6'd31);
    run_op("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 6'd32);
    run_op("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 6'd33);
  endtask

  task automatic test_stall();
    int   t;
    exp_t e;
    res_ready = 1'b0;
    issue_req(OP_MUL, 32'h0000_1234, 32'h0000_0010, 6'd9, t);
    collect_result("stall_mul", e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== e.data || res_tag !== e.tag || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: valid=%0b data=0x%08h tag=%0d ready=%0b, expected 1/0x%08h/%0d/0",
                 i, res_valid, res_data, res_tag, req_ready, e.data, e.tag);
      end
    end
    res_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: ready=%0b valid=%0b, expected 1/0", req_ready, res_valid);
    end
  endtask

  task automatic test_flush();
    int   t;
    int   seen;
    exp_t e;
    res_ready = 1'b1;
    issue_req(OP_DIV, 32'd1000, 32'd3, 6'd3, t);
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_early_valid[%0d]: res_valid_o=%0b, expected 0", k, res_valid);
      end
      @(negedge clk);
    end
    flush = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_low: req_ready_o=%0b, expected 0", req_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: ready=%0b valid=%0b, expected 1/0", req_ready, res_valid);
    end
    void'(sb_q.pop_front());
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_killed: res_valid_o high %0d cycles, expected 0", seen);
    end

    // Request presented together with flush must not be taken.
    flush     = 1'b1;
    req_uop   = OP_MUL;
    req_rs1   = 32'd2;
    req_rs2   = 32'd2;
    req_tag   = 6'd2;
    req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_ready: req_ready_o=%0b, expected 0", req_ready);
    end
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_req_dropped: res_valid_o high %0d cycles, expected 0", seen);
    end

    // Flush while a result is held discards it.
    res_ready = 1'b0;
    issue_req(OP_MUL, 32'd3, 32'd3, 6'd4, t);
    collect_result("flush_done_mul", e);
    flush     = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++;
    if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done: valid=%0b ready=%0b, expected 0/1", res_valid, req_ready);
    end
    @(negedge clk);
    run_op("after_flush_mul", OP_MUL, 32'd6, 32'd7, 6'd11);
  endtask

  task automatic test_back_to_back();
    int   t0, t1, t2, t3;
    exp_t e;
    res_ready = 1'b1;
    issue_req(OP_MUL,  32'd11,  32'd13, 6'd40, t0);
    collect_result("b2b_mul0", e);
    issue_req(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 6'd41, t1);
    collect_result("b2b_mul1", e);
    issue_req(OP_DIVU, 32'd100, 32'd7, 6'd42, t2);
    collect_result("b2b_div", e);
    issue_req(OP_DIV,  32'd5,   32'd0,  6'd43, t3);
    collect_result("b2b_div0", e);
    checks++;
    if (t1 - t0 != 3 || t2 - t1 != 3 || t3 - t2 != 35) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d/%0d/%0d, expected 3/3/35", t1 - t0, t2 - t1, t3 - t2);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0]  uop;
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      uop = 3'($urandom_range(0, 7));
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      if (i % 4 == 0) a = -a;
      run_op($sformatf("rand%0d", i), uop, a, b, 6'(i + 16));
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int seen;
    res_ready = 1'b1;
    issue_req(OP_DIV, 32'd1000, 32'd3, 6'd7, t);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_data !== 32'd0 || res_tag !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b data=0x%08h tag=%0d ready=%0b, expected 0/0/0/1",
               res_valid, res_data, res_tag, req_ready);
    end
    void'(sb_q.pop_front());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_result: res_valid_o high %0d cycles, expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_stall();
    test_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative integer multiply/divide execution unit that consumes the port-1 micro-ops produced by the integer op decoder: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. It sits behind the issue stage on the M-extension port, which the decoder selects whenever func7 is 0000001. The unit takes one operation at a time over a valid/ready request channel and returns one tagged result over a valid/ready writeback channel. It supports pipeline flush.

## Interface
- TAG_W, default 6: width of the destination tag carried with each operation (ROB/physical-register id).
- cpu_clock_i  input  1  sole clock; all state updates on the rising edge.
- cpu_reset_i  input  1  asynchronous, active-high reset.
- flush_i  input  1  kills any in-flight or held operation.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  unit can accept; equals (state==IDLE) & ~flush_i.
- req_uop_i  input  3  low 3 bits of the decoder uop: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_rs1_i  input  32  operand A (multiplicand / dividend).
- req_rs2_i  input  32  operand B (multiplier / divisor).
- req_tag_i  input  TAG_W  destination tag.
- res_valid_o  output  1  result held and valid.
- res_ready_i  input  1  writeback accepts the result.
- res_data_o  output  32  result value.
- res_tag_o  output  TAG_W  tag of the result.

## Operation
- Handshake: a request is accepted when req_valid_i & req_ready_o are high on a clock edge. The operands, uop and tag are latched on that edge.
- States:
  - IDLE: ready.
  - MUL: one cycle.
  - DIV: 32 iterations.
  - FIX: sign correction, one cycle.
  - DONE: holds the result.
- From IDLE on accept:
  - uop[2]==0 goes to MUL.
  - A division with divisor 0 or signed overflow goes straight to DONE.
  - Any other division goes to DIV with counter=0.
- MUL:
  - Each operand is extended to 33 bits: signed for rs1 in MULH/MULHSU and for rs2 in MULH; zero-extended otherwise.
  - The 66-bit product is registered.
  - MUL takes product[31:0]; MULH* take product[63:32].
  - Next state is DONE.
- DIV (restoring, on magnitudes):
  - Signed ops (DIV/REM) use |rs1| and |rs2|; unsigned ops use the raw values.
  - Each cycle: shift the 64-bit remainder:quotient left by 1 and trial-subtract the divisor from the upper 33 bits. If the result is non-negative, keep it and set the quotient LSB.
  - After counter==31, go to FIX.
- FIX:
  - Quotient is negated if signed and rs1/rs2 signs differ.
  - Remainder is negated if signed and rs1 negative.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
  - Next state is DONE.
- Special cases (RISC-V defined):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = rs1.
  - DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- DONE: res_valid_o=1 with data/tag stable until res_ready_i=1, then IDLE. No same-cycle re-accept: ready is low in DONE.
- Flush:
  - flush_i=1 in any state forces IDLE on the next edge and clears res_valid_o.
  - A result handshaking in the same cycle as flush is discarded.
  - A request presented during flush is not accepted (ready forced low).
- Reset: state=IDLE; res_valid_o=0; res_data_o=0; res_tag_o=0; counter and datapath registers 0. req_ready_o=1 once reset deasserts (absent flush).

## Timing
Cycle 0 is the accept edge.
- MUL family: result visible (res_valid_o=1) in cycle 2. Latency 2.
- Normal division: cycles 1–32 DIV, cycle 33 FIX, res_valid_o in cycle 34. Latency 34.
- Special-case division: res_valid_o in cycle 1. Latency 1.
- Throughput: one operation per (latency + 1) cycles when res_ready_i is held high. The DONE→IDLE edge costs one cycle.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous); no result is produced.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), tag 5 -> res_valid_o in cycle 2, data 0xFFFFFFEB, tag 5.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; each at latency 2.
- DIV −7/2 -> 0xFFFFFFFD in cycle 34; REM −7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF in cycle 1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; each at latency 1.
- MUL completes with res_ready_i low for 10 cycles -> res_valid_o/data/tag stable and req_ready_o=0 throughout. Raise res_ready_i -> req_ready_o=1 the next cycle.
- DIV 1000/3 accepted, flush_i pulsed in cycle 10 -> res_valid_o never asserts, req_ready_o=1 in cycle 11. Then MUL 6×7 is accepted -> 42 at latency 2.
- Assert cpu_reset_i in cycle 5 of a DIV -> outputs at reset values immediately, no result produced.
